// File: rtl/glitch_filter_bank.sv
// Multi-channel glitch filter: per-line synchroniser, programmable pulse rejection,
// filtered level with registered rise/fall strobes and a combined edge flag.
module glitch_filter_bank #(
   parameter int                  CHANNELS    = 2,
   parameter int                  SYNC_STAGES = 2,
   parameter int                  CNT_W       = 4,
   parameter logic [CHANNELS-1:0] INIT        = {CHANNELS{1'b1}}
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] in,
   input  logic                en,
   input  logic [CNT_W-1:0]    filt_len,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_edge
);

   logic [CHANNELS-1:0] rise_d;
   logic [CHANNELS-1:0] fall_d;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      logic [CNT_W-1:0]       cnt_q;
      logic [CNT_W-1:0]       cnt_d;
      logic                   out_q;
      logic                   out_d;
      logic                   rise_q;
      logic                   fall_q;
      logic                   rise_n;
      logic                   fall_n;

      // The chain keeps running while the filter is disabled so the level is
      // already settled when filtering resumes.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_q <= {SYNC_STAGES{INIT[i]}};
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in[i]};
         end
      end

      assign s = sync_q[SYNC_STAGES-1];

      // NOTE: every signal gets a default before the if-chain; a path that leaves
      // one unassigned would infer a latch.
      always_comb begin
         cnt_d  = '0;
         out_d  = out_q;
         rise_n = 1'b0;
         fall_n = 1'b0;
         if (en && (s != out_q)) begin
            if (cnt_q >= filt_len) begin
               out_d  = s;
               rise_n = s;
               fall_n = ~s;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q  <= '0;
            out_q  <= INIT[i];
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_n;
            fall_q <= fall_n;
         end
      end

      assign out[i]    = out_q;
      assign rise[i]   = rise_q;
      assign fall[i]   = fall_q;
      assign rise_d[i] = rise_n;
      assign fall_d[i] = fall_n;
   end

   // Built from the next-state strobes so it lines up with rise/fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         any_edge <= 1'b0;
      end else begin
         any_edge <= |(rise_d | fall_d);
      end
   end

endmodule

// File: tb/tb_glitch_filter_bank.sv
// Scoreboard bench for glitch_filter_bank: directed scenarios plus randomized phases,
// checked every cycle against a run-length reference model.
module tb_glitch_filter_bank;

   localparam int             CH   = 4;
   localparam int             SS   = 2;
   localparam int             CW   = 4;
   localparam logic [CH-1:0]  INIT = {CH{1'b1}};

   typedef struct packed {
      logic [CH-1:0] out;
      logic [CH-1:0] rise;
      logic [CH-1:0] fall;
      logic          any;
   } obs_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] in = '0;
   logic          en = 1'b0;
   logic [CW-1:0] filt_len = 4'd3;
   logic [CH-1:0] out;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;
   logic          any_edge;

   glitch_filter_bank #(
      .CHANNELS(CH), .SYNC_STAGES(SS), .CNT_W(CW), .INIT(INIT)
   ) dut (
      .clk(clk), .rst(rst), .in(in), .en(en), .filt_len(filt_len),
      .out(out), .rise(rise), .fall(fall), .any_edge(any_edge)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   obs_t exp_q[$];

   // Reference model: s is the input seen SS edges earlier; a channel flips once s
   // has disagreed with out on N+1 consecutive enabled edges.
   logic [CH-1:0] hist[$];
   int            run[CH];
   obs_t          m;

   task automatic model_edge(input logic r, input logic e, input int n, input logic [CH-1:0] i);
      logic [CH-1:0] s_vec;
      if (r) begin
         m.out  = INIT;
         m.rise = '0;
         m.fall = '0;
         m.any  = 1'b0;
         hist.delete();
         for (int k = 0; k < SS; k++) hist.push_back(INIT);
         for (int c = 0; c < CH; c++) run[c] = 0;
      end else begin
         s_vec  = hist[0];
         m.rise = '0;
         m.fall = '0;
         for (int c = 0; c < CH; c++) begin
            if (e && (s_vec[c] != m.out[c])) begin
               if (run[c] >= n) begin
                  m.out[c]  = s_vec[c];
                  m.rise[c] = s_vec[c];
                  m.fall[c] = ~s_vec[c];
                  run[c]    = 0;
               end else begin
                  run[c]++;
               end
            end else begin
               run[c] = 0;
            end
         end
         m.any = |(m.rise | m.fall);
         void'(hist.pop_front());
         hist.push_back(i);
      end
      exp_q.push_back(m);
   endtask

   // One clock of stimulus: drive at the falling edge, predict the post-edge state.
   task automatic step(input logic r, input logic e, input int n, input logic [CH-1:0] i);
      logic was_rst;
      @(negedge clk);
      was_rst  = rst;
      rst      = r;
      en       = e;
      filt_len = CW'(n);
      in       = i;
      if (r && !was_rst) begin
         #1;
         n_cmp++;
         if (out !== INIT || rise !== '0 || fall !== '0 || any_edge !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: out=%b rise=%b fall=%b any=%b, want out=%b strobes 0",
                     out, rise, fall, any_edge, INIT);
         end
      end
      model_edge(r, e, n, i);
   endtask

   // Monitor: every cycle the DUT presents a state; compare with the oldest prediction.
   initial begin
      obs_t act;
      obs_t want;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            act  = '{out: out, rise: rise, fall: fall, any: any_edge};
            n_cmp++;
            if (act !== want) begin
               n_bad++;
               $display("FAIL cycle_check t=%0t: got out=%b rise=%b fall=%b any=%b, want out=%b rise=%b fall=%b any=%b",
                        $time, act.out, act.rise, act.fall, act.any,
                        want.out, want.rise, want.fall, want.any);
            end
         end
      end
   end

   initial begin
      logic [CH-1:0] cur;
      int            n;
      int            p;
      int            drained;

      // Reset with inputs low, then release with N=3: all channels fall together.
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 3, '0);
      for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 3, '0);
      for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 3, '1);

      // Glitch rejection on channel 0: low pulses of 1..4 clocks with N=3.
      for (int len = 1; len <= 4; len++) begin
         for (int k = 0; k < len; k++) step(1'b0, 1'b1, 3, 4'b1110);
         for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 3, 4'b1111);
      end

      // Pass-through with N=0: single-cycle low on channel 1.
      step(1'b0, 1'b1, 0, 4'b1101);
      for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 0, 4'b1111);

      // Restart: N=5, low 4, high 1, low 6, then high again.
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 5, 4'b1110);
      step(1'b0, 1'b1, 5, 4'b1111);
      for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 5, 4'b1110);
      for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 5, 4'b1111);

      // Disabled: inputs toggle freely, outputs must stay frozen.
      for (int k = 0; k < 30; k++) step(1'b0, 1'b0, 1, CH'($urandom));
      for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1, 4'b1111);

      // Lowering filt_len below a running count: N=7 for several clocks, then N=2.
      for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 7, 4'b1110);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 2, 4'b1110);
      for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 2, 4'b1111);

      // All channels fall in the same cycle with N=1.
      for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1, 4'b1111);
      for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1, 4'b0000);

      // Randomized phases: filter length, toggle density, enable, resets.
      cur = '0;
      for (int ph = 0; ph < 14; ph++) begin
         n = (ph % 5 == 4) ? $urandom_range(8, 15) : $urandom_range(0, 5);
         case (ph % 3)
            0:       p = 50;
            1:       p = 20;
            default: p = 7;
         endcase
         for (int k = 0; k < 200; k++) begin
            for (int c = 0; c < CH; c++)
               if ($urandom_range(0, 99) < p) cur[c] = ~cur[c];
            if ($urandom_range(0, 99) < 3) n = $urandom_range(0, 9);
            step(($urandom_range(0, 999) < 4), ($urandom_range(0, 99) < 92), n, cur);
         end
      end
      step(1'b0, 1'b1, 2, cur);

      drained = 0;
      for (int k = 0; k < 20 && !drained; k++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0) drained = 1;
      end
      if (!drained) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
